relay_register_bank: RTL and testbench

//  Parametrised bank of relay-style registers sharing one write path and a wired-OR read bus.

---
 rtl/relay_pkg.sv | 23 ++
 rtl/relay_reg_cell.sv | 31 +++
 rtl/relay_register_bank.sv | 141 ++++++++++++++
 tb/tb_relay_register_bank.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared types and default sizing for the relay computer register units.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package relay_pkg;

    // Write sequence of a relay register: drop hold, settle, latch.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SETTLE = 2'd2
    } relay_wr_state_t;

    // Default geometry shared by the relay units of the model.
    localparam int RELAY_NUM_REGS      = 8;
    localparam int RELAY_WIDTH         = 8;
    localparam int RELAY_SETTLE_CYCLES = 2;

    // Width of a down-counter that must hold values 0..settle-1 without wrapping.
    function automatic int relay_cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/relay_reg_cell.sv
// One relay register: WIDTH data bits plus a hold/valid flag.
// Latency: clear/release/latch take effect at the next rising edge.
// Backpressure: none; the owning bank never asserts clear and latch together.
module relay_reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             latch,
    input  logic             release_hold,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] value,
    output logic             valid
);

    // Dropping hold (clear or release) empties the relay; latching picks up new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            valid <= 1'b0;
        end else if (clear || release_hold) begin
            value <= '0;
            valid <= 1'b0;
        end else if (latch) begin
            value <= data;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/relay_register_bank.sv
// Bank of relay registers with one shared write path and a registered wired-OR read bus.
// Latency: write accepted at edge T is visible after edge T+1+SETTLE_CYCLES; reads are 1 cycle.
// Backpressure: load_ready is low while a write clears/settles; requests then are dropped, not queued.
module relay_register_bank
    import relay_pkg::*;
#(
    parameter int NUM_REGS      = RELAY_NUM_REGS,
    parameter int WIDTH         = RELAY_WIDTH,
    parameter int SETTLE_CYCLES = RELAY_SETTLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic [NUM_REGS-1:0] load_sel,
    input  logic [WIDTH-1:0]    load_data,
    output logic                load_ready,
    input  logic [NUM_REGS-1:0] release_sel,
    input  logic [NUM_REGS-1:0] read_sel,
    output logic [WIDTH-1:0]    bus_out,
    output logic                bus_oe,
    output logic [NUM_REGS-1:0] reg_valid
);

    localparam int                CNT_W    = relay_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    relay_wr_state_t      state;
    relay_wr_state_t      state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 accept;
    logic                 do_clear;
    logic                 do_latch;
    logic [NUM_REGS-1:0]  cap_sel;
    logic [WIDTH-1:0]     cap_data;
    logic                 write_busy;
    logic [NUM_REGS-1:0]  rel_mask;
    logic [WIDTH-1:0]     cell_value [NUM_REGS];
    logic [WIDTH-1:0]     rd_or;

    // Write FSM state and settle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Write FSM: accept in IDLE, drop hold for one cycle, settle, then latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_ready = 1'b0;
        accept     = 1'b0;
        do_clear   = 1'b0;
        do_latch   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_req) begin
                    accept    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                do_clear  = 1'b1;
                cnt_nxt   = CNT_LOAD;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == '0) begin
                    do_latch  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture target set and data at accept so the inputs may change mid-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_sel  <= '0;
            cap_data <= '0;
        end else if (accept) begin
            cap_sel  <= load_sel;
            cap_data <= load_data;
        end
    end

    // A write in progress owns its target registers; releases aimed at them are dropped.
    assign write_busy = (state != IDLE);
    assign rel_mask   = write_busy ? (release_sel & ~cap_sel) : release_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
            relay_reg_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk          (clk),
                .rst          (rst),
                .clear        (do_clear & cap_sel[gi]),
                .latch        (do_latch & cap_sel[gi]),
                .release_hold (rel_mask[gi]),
                .data         (cap_data),
                .value        (cell_value[gi]),
                .valid        (reg_valid[gi])
            );
        end
    endgenerate

    // Wired-OR of every selected register that currently holds a value.
    always_comb begin
        rd_or = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (read_sel[i] && reg_valid[i]) begin
                rd_or = rd_or | cell_value[i];
            end
        end
    end

    // Registered read bus and output-enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_out <= '0;
            bus_oe  <= 1'b0;
        end else begin
            bus_out <= rd_or;
            bus_oe  <= |read_sel;
        end
    end

endmodule

// File: tb/tb_relay_register_bank.sv
// Self-checking bench for relay_register_bank: directed scenarios plus randomized traffic.
// Outputs are compared every cycle against a timestamp-based model of the write/read rules.
// Directed scenarios add literal expectations that pin the model.
module tb_relay_register_bank;

    localparam int N = 8;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_req;
    logic [N-1:0] load_sel;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic [N-1:0] release_sel;
    logic [N-1:0] read_sel;
    logic [W-1:0] bus_out;
    logic         bus_oe;
    logic [N-1:0] reg_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [W-1:0] m_reg [N];
    logic [N-1:0] m_val;
    bit           m_busy;
    int           m_acc;
    logic [N-1:0] m_sel;
    logic [W-1:0] m_data;
    logic [W-1:0] m_bus;
    logic         m_oe;
    int           cyc;

    relay_register_bank #(
        .NUM_REGS      (N),
        .WIDTH         (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .load_sel    (load_sel),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .release_sel (release_sel),
        .read_sel    (read_sel),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .reg_valid   (reg_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_reg[i] = '0;
        m_val  = '0;
        m_busy = 1'b0;
        m_acc  = 0;
        m_sel  = '0;
        m_data = '0;
        m_bus  = '0;
        m_oe   = 1'b0;
        cyc    = 0;
    endtask

    // One rising edge of the model: a write accepted at edge A clears its targets at
    // edge A+1 and latches at edge A+1+S; reads reflect the pre-edge register contents.
    task automatic model_edge(input logic lr, input logic [N-1:0] ls, input logic [W-1:0] ld,
                              input logic [N-1:0] rl, input logic [N-1:0] rs);
        logic [W-1:0] nb;
        logic [N-1:0] rel;
        nb = '0;
        for (int i = 0; i < N; i++) if (rs[i] && m_val[i]) nb = nb | m_reg[i];
        m_bus = nb;
        m_oe  = |rs;
        rel   = m_busy ? (rl & ~m_sel) : rl;
        if (m_busy) begin
            if (cyc == m_acc + 1) begin
                for (int i = 0; i < N; i++) if (m_sel[i]) begin m_reg[i] = '0; m_val[i] = 1'b0; end
            end
            if (cyc == m_acc + 1 + S) begin
                for (int i = 0; i < N; i++) if (m_sel[i]) begin m_reg[i] = m_data; m_val[i] = 1'b1; end
                m_busy = 1'b0;
            end
        end else if (lr) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_sel  = ls;
            m_data = ld;
        end
        for (int i = 0; i < N; i++) if (rel[i]) begin m_reg[i] = '0; m_val[i] = 1'b0; end
        cyc++;
    endtask

    task automatic compare_outputs();
        check("load_ready", 32'(load_ready), 32'(!m_busy));
        check("reg_valid",  32'(reg_valid),  32'(m_val));
        check("bus_out",    32'(bus_out),    32'(m_bus));
        check("bus_oe",     32'(bus_oe),     32'(m_oe));
    endtask

    // Apply current inputs for one clock, advance the model, compare #1 after the edge.
    task automatic step();
        logic         lr;
        logic [N-1:0] ls;
        logic [W-1:0] ld;
        logic [N-1:0] rl;
        logic [N-1:0] rs;
        lr = load_req; ls = load_sel; ld = load_data; rl = release_sel; rs = read_sel;
        @(posedge clk);
        model_edge(lr, ls, ld, rl, rs);
        #1;
        compare_outputs();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (load_ready) return;
            step();
        end
        check("wait_ready_timeout", 32'(load_ready), 32'd1);
    endtask

    task automatic do_write(input logic [N-1:0] sel, input logic [W-1:0] data);
        load_req  = 1'b1;
        load_sel  = sel;
        load_data = data;
        step();
        load_req  = 1'b0;
        wait_idle();
    endtask

    initial begin
        int lowcnt;
        int accepts;
        rst = 1'b1; load_req = 1'b0; load_sel = '0; load_data = '0;
        release_sel = '0; read_sel = '0;
        model_reset();
        #12;
        compare_outputs();
        check("reset_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 1: write A5 to reg0, ready low for 1+S cycles, read back
        load_req = 1'b1; load_sel = 8'h01; load_data = 8'hA5;
        step();
        load_req = 1'b0;
        lowcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (load_ready) break;
            lowcnt++;
            step();
        end
        check("ready_low_cycles", 32'(lowcnt), 32'(1 + S));
        check("valid0_after_write", 32'(reg_valid[0]), 32'd1);
        read_sel = 8'h01;
        step();
        check("read_reg0_A5", 32'(bus_out), 32'hA5);
        check("read_reg0_oe", 32'(bus_oe), 32'd1);

        // 2: OR of two registers, then no selection
        read_sel = '0;
        do_write(8'h02, 8'h0F);
        do_write(8'h04, 8'hF0);
        read_sel = 8'h06;
        step();
        check("or_reg1_reg2", 32'(bus_out), 32'hFF);
        read_sel = '0;
        step();
        check("nosel_bus", 32'(bus_out), 32'h00);
        check("nosel_oe", 32'(bus_oe), 32'd0);

        // 3: overwrite reg0 with 3C while reading it every cycle
        read_sel = 8'h01;
        load_req = 1'b1; load_sel = 8'h01; load_data = 8'h3C;
        step();
        load_req = 1'b0;
        check("ovw_edge0", 32'(bus_out), 32'hA5);
        step(); step();
        check("ovw_mid_zero", 32'(bus_out), 32'h00);
        step(); step();
        check("ovw_final", 32'(bus_out), 32'h3C);

        // 4: release reg0, then release during a write to reg0
        release_sel = 8'h01;
        step();
        release_sel = '0;
        check("release_valid0", 32'(reg_valid[0]), 32'd0);
        step();
        check("release_read", 32'(bus_out), 32'h00);
        check("release_read_oe", 32'(bus_oe), 32'd1);
        load_req = 1'b1; load_sel = 8'h01; load_data = 8'h99;
        step();
        load_req = 1'b0;
        release_sel = 8'h01;
        for (int k = 0; k < 40 && !load_ready; k++) step();
        release_sel = '0;
        check("write_beats_release", 32'(reg_valid[0]), 32'd1);
        step();
        check("write_beats_release_data", 32'(bus_out), 32'h99);

        // 5: reset during SETTLE of a write of 77 to reg3
        read_sel = 8'h02;
        load_req = 1'b1; load_sel = 8'h08; load_data = 8'h77;
        step();
        load_req = 1'b0;
        step();
        check("pre_reset_bus", 32'(bus_out), 32'h0F);
        check("pre_reset_busy", 32'(load_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_valid", 32'(reg_valid), 32'd0);
        check("rst_bus", 32'(bus_out), 32'd0);
        check("rst_oe", 32'(bus_oe), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        read_sel = 8'h08;
        for (int k = 0; k < S + 3; k++) step();
        check("reg3_after_reset", 32'(bus_out), 32'h00);
        check("reg3_valid_after_reset", 32'(reg_valid[3]), 32'd0);

        // 6: continuous requests to all registers
        read_sel = '0;
        load_req = 1'b1; load_sel = 8'hFF; load_data = 8'h55;
        accepts = 0;
        for (int k = 0; k < 3 * (S + 2); k++) begin
            if (load_ready) accepts++;
            step();
        end
        load_req = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd3);
        wait_idle();
        for (int i = 0; i < N; i++) begin
            read_sel = N'(1 << i);
            step();
            check("all_55", 32'(bus_out), 32'h55);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            load_req    = ($urandom_range(0, 3) == 0);
            load_sel    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            load_data   = W'($urandom);
            release_sel = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            read_sel    = ($urandom_range(0, 1) == 0) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
